// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between an instruction
// fetch port and a load/store port. Issue is combinational in the cycle a
// request is eligible, and the matching ack pulses exactly one cycle later.
// Data wins ties. Optional anti-starvation guard, enabled by defining the
// macro ARB_STARVE_GUARD_EN: once the fetch port has lost STARVE_LIMIT
// consecutive arbitrations, it wins the next one it is eligible for.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  // The state names the owner of the access issued in the previous cycle,
  // so it doubles as the ack decode.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t state_reg;
  logic   inst_elig;
  logic   data_elig;
  logic   grant_inst;
  logic   grant_data;

  // A requester whose ack is high this cycle is still presenting the request
  // that just completed, so it must not be issued again. Nothing is issued
  // while reset is held.
  always_comb begin
    inst_elig = resetn & inst_req & (state_reg != BUSY_I);
    data_elig = resetn & data_req & (state_reg != BUSY_D);
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;
  logic       starve_hit;

  assign starve_hit = (starve_cnt_reg >= LIMIT);

  // Data normally wins ties; a starved fetch takes one arbitration from it.
  always_comb begin
    grant_inst = inst_elig & (~data_elig | starve_hit);
    grant_data = data_elig & ~grant_inst;
  end

  // Count consecutive losses of an eligible fetch; a grant or an idle fetch
  // port restarts the count. Saturates at the counter's maximum.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!inst_req || grant_inst) begin
      starve_cnt_next = 4'd0;
    end else if (inst_elig && grant_data && (starve_cnt_reg != 4'hF)) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_reg <= 4'd0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`else
  // Without the guard the limit has no effect; fold it away quietly.
  logic unused_limit;
  assign unused_limit = ^LIMIT;

  // Strict data priority: fetch only gets the SRAM when data is not eligible.
  always_comb begin
    grant_inst = inst_elig & ~data_elig;
    grant_data = data_elig;
  end
`endif

  // Record which port was issued this cycle; that port is acked next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
    end else begin
      if (grant_data) begin
        state_reg <= BUSY_D;
      end else if (grant_inst) begin
        state_reg <= BUSY_I;
      end else begin
        state_reg <= IDLE;
      end
    end
  end

  // Drive the shared SRAM from the winner; all fields are zero when idle,
  // and a fetch never writes.
  always_comb begin
    sram_en    = grant_inst | grant_data;
    sram_wen   = 4'd0;
    sram_addr  = 32'd0;
    sram_wdata = 32'd0;
    if (grant_data) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (grant_inst) begin
      sram_addr  = inst_addr;
    end
  end

  assign inst_ack   = (state_reg == BUSY_I);
  assign data_ack   = (state_reg == BUSY_D);
  assign inst_rdata = sram_rdata;
  assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios plus randomized traffic for
// sram_port_arbiter, checked cycle by cycle against a transaction-level
// reference model and a behavioural SRAM. Build with +define+ARB_STARVE_GUARD_EN
// to check the starvation guard variant.
module tb_sram_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_ack;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_ack   (inst_ack),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_ack   (data_ack),
    .data_rdata (data_rdata),
    .sram_en    (sram_en),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // Initial memory image shared by the SRAM and the model.
  function automatic logic [31:0] init_val(input int i);
    logic [31:0] v;
    v = (32'(i) * 32'h9E3779B1) ^ 32'hC3A50F1E;
    if (i == 0) v = 32'h24080001;
    return v;
  endfunction

  // Behavioural single-port SRAM: read data one cycle after an enabled read,
  // junk on every other cycle.
  logic [31:0] sram_mem [64];
  logic [31:0] rd_q;
  logic        init_mem;
  assign sram_rdata = rd_q;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= init_val(i);
      rd_q <= $urandom;
    end else if (sram_en && sram_wen == 4'd0) begin
      rd_q <= sram_mem[sram_addr[7:2]];
    end else begin
      if (sram_en) begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) sram_mem[sram_addr[7:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
      rd_q <= $urandom;
    end
  end

  // Reference model state: what should be acked this cycle and with what word.
  logic [31:0] model_mem [64];
  bit          exp_iack  = 1'b0;
  bit          exp_dack  = 1'b0;
  bit          exp_dload = 1'b0;
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;
  bit          seen_i = 1'b0;
  bit          seen_d = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
  int          losses = 0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h", tag, $time, got, want);
    end
  endtask

  // One model step, run at the falling edge with inputs settled.
  task automatic step();
    bit          ie;
    bit          de;
    bit          gi;
    bit          gd;
    logic [5:0]  ix;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wen;
    if (!resetn) begin
      exp_iack = 1'b0;
      exp_dack = 1'b0;
    end
    check_val("inst_ack", 32'(inst_ack), 32'(exp_iack));
    check_val("data_ack", 32'(data_ack), 32'(exp_dack));
    if (exp_iack) check_val("inst_rdata", inst_rdata, exp_irdata);
    if (exp_dack && exp_dload) check_val("data_rdata", data_rdata, exp_drdata);
    seen_i = (inst_ack === 1'b1);
    seen_d = (data_ack === 1'b1);
    if (!resetn) begin
      check_val("rst_sram_en", 32'(sram_en), 32'd0);
      check_val("rst_sram_wen", 32'(sram_wen), 32'd0);
`ifdef ARB_STARVE_GUARD_EN
      losses = 0;
`endif
      return;
    end
    ie = inst_req && !exp_iack;
    de = data_req && !exp_dack;
`ifdef ARB_STARVE_GUARD_EN
    gi = ie && (!de || losses >= STARVE_LIMIT);
`else
    gi = ie && !de;
`endif
    gd = de && !gi;
    e_addr  = gd ? data_addr  : (gi ? inst_addr : 32'd0);
    e_wen   = gd ? data_wen   : 4'd0;
    e_wdata = gd ? data_wdata : 32'd0;
    check_val("sram_en", 32'(sram_en), 32'(gi || gd));
    check_val("sram_addr", sram_addr, e_addr);
    check_val("sram_wen", 32'(sram_wen), 32'(e_wen));
    check_val("sram_wdata", sram_wdata, e_wdata);
    if (gd) begin
      ix = data_addr[7:2];
      exp_dload = (data_wen == 4'd0);
      if (exp_dload) begin
        exp_drdata = model_mem[ix];
      end else begin
        for (int b = 0; b < 4; b++)
          if (data_wen[b]) model_mem[ix][8*b +: 8] = data_wdata[8*b +: 8];
      end
      $display("txn t=%0t data %s addr=%h wen=%h wdata=%h", $time,
               exp_dload ? "load " : "store", data_addr, data_wen, data_wdata);
    end
    if (gi) begin
      exp_irdata = model_mem[inst_addr[7:2]];
      $display("txn t=%0t inst fetch addr=%h", $time, inst_addr);
    end
`ifdef ARB_STARVE_GUARD_EN
    if (!inst_req || gi) losses = 0;
    else if (ie && gd && losses < 15) losses = losses + 1;
`endif
    exp_iack = gi;
    exp_dack = gd;
  endtask

  // Check one cycle, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  // Run until both outstanding requests are acked (bounded).
  task automatic run_until_done(input int budget);
    int n;
    n = 0;
    while ((inst_req || data_req) && n < budget) begin
      tick();
      if (seen_i) inst_req = 1'b0;
      if (seen_d) data_req = 1'b0;
      n++;
    end
    check_val("drain_in_budget", 32'(inst_req || data_req), 32'd0);
  endtask

  // Random requesters: hold until ack, then drop or present a new request.
  task automatic drive_random();
    if (inst_req && seen_i) inst_req = 1'b0;
    if (data_req && seen_d) data_req = 1'b0;
    if (!inst_req && $urandom_range(99) < 60) begin
      inst_req  = 1'b1;
      inst_addr = 32'hBFC00000 | (32'($urandom_range(63)) << 2);
    end
    if (!data_req && $urandom_range(99) < 70) begin
      data_req   = 1'b1;
      data_addr  = 32'h80000000 | (32'($urandom_range(63)) << 2);
      data_wen   = ($urandom_range(1) == 1) ? 4'($urandom) : 4'd0;
      data_wdata = $urandom;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) model_mem[i] = init_val(i);
    resetn     = 1'b0;
    init_mem   = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = 32'd0;
    data_req   = 1'b0;
    data_wen   = 4'd0;
    data_addr  = 32'd0;
    data_wdata = 32'd0;
    @(posedge clk);
    #1;
    init_mem = 1'b0;
    tick();
    tick();

    // Pending fetch during reset must not reach the SRAM; it issues on the
    // first edge after release and returns the boot word.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00000;
    tick();
    resetn = 1'b1;
    run_until_done(10);

    // Simultaneous fetch and load: data first, fetch back to back.
    inst_req  = 1'b1;
    inst_addr = 32'hBFC00008;
    data_req  = 1'b1;
    data_wen  = 4'd0;
    data_addr = 32'h80000010;
    run_until_done(10);

    // Partial store, then read it back.
    data_req   = 1'b1;
    data_wen   = 4'b0011;
    data_addr  = 32'h80000004;
    data_wdata = 32'h0000BEEF;
    run_until_done(10);
    data_req   = 1'b1;
    data_wen   = 4'd0;
    data_wdata = 32'd0;
    run_until_done(10);

    // Reset asserted the cycle after a data issue abandons the access.
    data_req  = 1'b1;
    data_wen  = 4'd0;
    data_addr = 32'h80000020;
    @(negedge clk);
    step();
    resetn   = 1'b0;
    data_req = 1'b0;
    @(posedge clk);
    #1;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    tick();
    data_req = 1'b1;
    run_until_done(10);

    // Randomized mixed traffic.
    for (int c = 0; c < 2000; c++) begin
      drive_random();
      tick();
    end
    if (inst_req && seen_i) inst_req = 1'b0;
    if (data_req && seen_d) data_req = 1'b0;
    run_until_done(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
